// File: rtl/byte_fifo.sv
// ============================================================================
// Module   : byte_fifo
// Brief    : DEPTH x 8-bit synchronous FIFO with valid/ready handshakes on
//            both sides. Optional macro BYTE_FIFO_OVERFLOW_EN adds a sticky
//            o_overflow flag for writes offered while full.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_wr_valid,
  output logic          o_wr_ready,
  input  logic [7:0]    i_wr_data,
  output logic          o_rd_valid,
  input  logic          i_rd_ready,
  output logic [7:0]    o_data,
`ifdef BYTE_FIFO_OVERFLOW_EN
  output logic          o_overflow,
`endif
  output logic [AW:0]   o_count
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          wr_en;
  logic          rd_en;

  // Handshake flags come only from the stored count, so there is no
  // combinational path from i_rd_ready to o_wr_ready.
  assign o_wr_ready = (count < FULL_COUNT);
  assign o_rd_valid = (count != '0);
  assign o_data     = o_rd_valid ? mem[rd_ptr] : 8'h00;
  assign o_count    = count;

  assign wr_en = i_wr_valid && o_wr_ready;
  assign rd_en = o_rd_valid && i_rd_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset_n && wr_en) begin
      mem[wr_ptr] <= i_wr_data;
    end
  end

  // DEPTH is a power of two, so pointer overflow wraps naturally.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef BYTE_FIFO_OVERFLOW_EN
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_overflow <= 1'b0;
    end else if (i_wr_valid && !o_wr_ready) begin
      o_overflow <= 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire
